// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
//
// Contents: register offsets, STATUS bit positions, FSM state encodings,
// the interconnect window constants and a STATUS word packing helper.
package uart_tx_mmio_pkg;

  // Window claimed by the UART TX block in the interconnect address decode.
  localparam logic [31:0] UART_TX_BASE = 32'h4000_1000;
  localparam logic [31:0] UART_TX_END  = 32'h4000_100F;

  // Byte offsets inside the window.
  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  // Only the word offset (addr[3:2]) is decoded.
  localparam logic [1:0] WORD_TXDATA = REG_TXDATA[3:2];
  localparam logic [1:0] WORD_STATUS = REG_STATUS[3:2];

  // STATUS bit positions.
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 5;

  // Transmit FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Assemble the STATUS read word; unassigned bits read as zero.
  function automatic logic [31:0] status_word(
    input logic                  full,
    input logic                  empty,
    input logic                  busy,
    input logic                  ovf,
    input logic [STAT_CNT_W-1:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART TX path.
// Latency: a push is visible on dout/empty the cycle after the push edge.
// Backpressure: push while full is ignored; pop while empty is ignored.
//
// Ports: clk, rst (sync, active high), push/din (write side),
// pop/dout (read side, dout valid whenever !empty), full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Acceptance is judged on the occupancy before the edge, so a push into
  // a full FIFO is refused even if a pop frees a slot at the same edge.
  always_comb begin
    push_ok  = push && (count_q != DEPTH_C);
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores queue bytes, sent 8N1 LSB first.
// Latency: store at edge N -> popped at N+1 -> start bit on tx from N+1; frame 10*DIV cycles.
// Backpressure: none on the bus; a store into a full FIFO is dropped and sets sticky overflow.
//
// Ports: clk, rst (sync, active high); addr/ren/wen/wdata bus inputs from the
// interconnect; rdata combinational read data; tx serial line (idle high);
// tx_idle high when nothing is queued and the shifter is idle.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_idle
);

  // Clocks per bit, rounded to nearest; must be at least 2.
  localparam int DIV   = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             wr_txdata, wr_status;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FCW-1:0]   fifo_count;
  logic             bit_done, busy;

  // ren has no side effects; upper store bits and addr[1:0] are not decoded.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ren, addr[1:0], wdata[31:8]};

  assign wr_txdata = wen && (addr[3:2] == WORD_TXDATA);
  assign wr_status = wen && (addr[3:2] == WORD_STATUS);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Set and clear need different offsets, so they never collide.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_status && wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bit_done = (cnt_q == DIV_LAST);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. The line level is derived from the *next* state so the
  // registered tx changes on the same edge the FSM enters a new bit period.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign tx      = tx_q;
  assign tx_idle = fifo_empty && (state_q == ST_IDLE);

  // Read data is purely combinational; the interconnect holds it across stalls.
  assign rdata = (addr[3:2] == WORD_STATUS)
               ? status_word(fifo_full, fifo_empty, busy, ovf_q,
                             STAT_CNT_W'(fifo_count))
               : 32'h0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int DIV      = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        ren   = 1'b0;
  logic        wen   = 1'b0;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_idle;

  uart_tx_mmio #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .ren     (ren),
    .wen     (wen),
    .wdata   (wdata),
    .rdata   (rdata),
    .tx      (tx),
    .tx_idle (tx_idle)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; rst_seen = rst sampled at last edge.
  longint cyc      = 0;
  bit     rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted byte is described by its push edge and the edge it leaves
  // the FIFO; everything else is derived from those times arithmetically.
  typedef struct { logic [7:0] b; longint p; } exp_t;
  exp_t       exp_q[$];
  longint     acc_push[$];
  longint     acc_pop[$];
  logic [7:0] acc_byte[$];
  bit         m_ovf    = 1'b0;
  longint     last_pop = -1000000;

  // Bytes held in the FIFO just after edge k.
  function automatic int m_count(longint k);
    int n = 0;
    foreach (acc_push[i]) if (acc_push[i] <= k && acc_pop[i] > k) n++;
    return n;
  endfunction

  // A frame occupies the FRAME cycles following its pop edge.
  function automatic bit m_busy(longint k);
    foreach (acc_pop[i]) if (acc_pop[i] <= k && k <= acc_pop[i] + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_idle(longint k);
    return (m_count(k) == 0) && !m_busy(k);
  endfunction

  function automatic logic m_tx(longint k);
    int idx;
    foreach (acc_pop[i]) begin
      if (acc_pop[i] <= k && k <= acc_pop[i] + FRAME - 1) begin
        idx = int'((k - acc_pop[i]) / DIV);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return acc_byte[i][3'(idx - 1)];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status(longint k);
    int c;
    logic [31:0] s;
    c = m_count(k);
    s = 32'h0;
    s[0]    = (c == DEPTH);
    s[1]    = (c == 0);
    s[2]    = m_busy(k);
    s[3]    = m_ovf;
    s[12:8] = 5'(c);
    return s;
  endfunction

  function automatic logic [31:0] m_rdata(logic [3:0] a, longint k);
    return (a[3:2] == 2'b01) ? m_status(k) : 32'h0;
  endfunction

  // Apply a store that lands on edge e.
  function automatic void model_write(longint e, logic [3:0] a, logic [31:0] d);
    exp_t   x;
    longint p;
    if (a[3:2] == 2'b00) begin
      if (m_count(e - 1) == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
        acc_push.push_back(e);
        acc_pop.push_back(p);
        acc_byte.push_back(d[7:0]);
        last_pop = p;
        x.b = d[7:0];
        x.p = p;
        exp_q.push_back(x);
      end
    end else if (a[3:2] == 2'b01 && d[3]) begin
      m_ovf = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    acc_push.delete();
    acc_pop.delete();
    acc_byte.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    last_pop = -1000000;
  endfunction

  // ---------------- monitors ----------------
  // Serial receiver: decodes each frame at mid-bit and checks it against the
  // oldest expected byte, including the cycle on which its start bit began.
  initial begin : sb_monitor
    bit         in_frame;
    longint     st_cyc;
    int         off;
    logic [9:0] bits;
    exp_t       e;
    in_frame = 1'b0;
    st_cyc   = 0;
    bits     = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          st_cyc   = cyc;
        end
      end else begin
        off = int'(cyc - st_cyc);
        if (off % DIV == DIV / 2) begin
          bits[4'(off / DIV)] = tx;
          if (off / DIV == 9) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL sb_unexpected_frame at cycle %0d: got byte 0x%02h, expected no frame", cyc, bits[8:1]);
            end else begin
              e = exp_q.pop_front();
              chk("sb_byte", {24'h0, bits[8:1]}, {24'h0, e.b});
              chk("sb_start_cycle", 32'(st_cyc), 32'(e.p));
              chk("sb_start_bit", {31'h0, bits[0]}, 32'h0);
              chk("sb_stop_bit", {31'h0, bits[9]}, 32'h1);
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle line and idle-flag check against the model.
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!rst_seen) begin
        chk("tx_line", {31'h0, tx}, {31'h0, m_tx(cyc)});
        chk("tx_idle", {31'h0, tx_idle}, {31'h0, m_idle(cyc)});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    ren   = 1'($urandom_range(0, 1));
    model_write(cyc + 1, a, d);
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a);
    addr = a;
    ren  = 1'b1;
    #1;
    chk(name, rdata, m_rdata(a, cyc));
    ren = 1'b0;
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_idle !== 1'b1 || !m_idle(cyc)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_tx_idle", {31'h0, tx_idle}, 32'h1);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    longint     n;
    longint     p;
    int         op;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    rd_chk("reset_status_model", 4'h4);
    chk("reset_status", rdata, 32'h0000_0002);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    chk("reset_tx_idle", {31'h0, tx_idle}, 32'h1);
    rd_chk("reset_txdata_read", 4'h0);
    repeat (5) @(negedge clk);

    // Single byte 0x55 with explicit frame timing.
    n = cyc + 1;
    wr(4'h0, 32'h0000_0055);
    chk("f55_pre_start", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("f55_start_first", {31'h0, tx}, 32'h0);
    wait_until(n + 16);
    chk("f55_start_last", {31'h0, tx}, 32'h0);
    @(negedge clk);
    chk("f55_bit0", {31'h0, tx}, 32'h1);
    wait_until(n + 160);
    chk("f55_idle_low", {31'h0, tx_idle}, 32'h0);
    @(negedge clk);
    chk("f55_idle_rise", {31'h0, tx_idle}, 32'h1);
    drain();

    // Two back-to-back frames.
    wr(4'h0, 32'h0000_00A1);
    wr(4'h0, 32'h0000_003C);
    drain();

    // Overflow: six stores, first one popped immediately, sixth dropped.
    wr(4'h0, 32'h0000_0011);
    for (int i = 0; i < 5; i++) wr(4'h0, $urandom);
    rd_chk("ovf_status_model", 4'h4);
    chk("ovf_status", rdata, 32'h0000_040D);
    wr(4'h4, 32'h0000_0008);
    rd_chk("ovf_clear_model", 4'h4);
    chk("ovf_clear", rdata, 32'h0000_0405);
    drain();

    // Reset mid-frame with two bytes queued.
    wr(4'h0, 32'h0000_00C3);
    wr(4'h0, 32'h0000_005A);
    wr(4'h0, 32'h0000_00F0);
    p = acc_pop[acc_pop.size() - 3];
    wait_until(p + 39);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midrst_tx", {31'h0, tx}, 32'h1);
    rd_chk("midrst_status_model", 4'h4);
    chk("midrst_status", rdata, 32'h0000_0002);
    repeat (200) @(negedge clk);
    chk("midrst_still_idle", {31'h0, tx_idle}, 32'h1);

    // Full FIFO, store on the same edge as a pop: store refused.
    wr(4'h0, 32'h0000_0081);
    for (int i = 0; i < 4; i++) wr(4'h0, $urandom);
    rd_chk("full_status_model", 4'h4);
    p = acc_pop[acc_pop.size() - 4];
    wait_until(p - 1);
    wr(4'h0, 32'h0000_00EE);
    rd_chk("popedge_status_model", 4'h4);
    chk("popedge_status", rdata, 32'h0000_030C);
    wr(4'h4, 32'h0000_0008);
    drain();

    // Randomized traffic across all offsets.
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      d  = $urandom;
      if (op <= 5) begin
        wr({2'b00, 2'($urandom_range(0, 3))}, d);
      end else if (op == 6) begin
        wr({2'b01, 2'($urandom_range(0, 3))}, d);
      end else if (op == 7) begin
        wr({1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))}, d);
      end else begin
        rd_chk("rand_read", 4'($urandom_range(0, 15)));
        @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(20, 200)) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rd_chk("final_status", 4'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
